// File: rtl/video_timing_pkg.sv
// Shared video mode descriptions for the pixel-clock timing generator.
// Each mode is stored as active, front porch, sync and back porch lengths per axis.
package video_timing_pkg;

    localparam int TW = 12;

    typedef struct packed {
        logic [TW-1:0] h_active;
        logic [TW-1:0] h_fp;
        logic [TW-1:0] h_sw;
        logic [TW-1:0] h_bp;
        logic [TW-1:0] v_active;
        logic [TW-1:0] v_fp;
        logic [TW-1:0] v_sw;
        logic [TW-1:0] v_bp;
        logic          hs_pol;
        logic          vs_pol;
    } video_mode_t;

    localparam int MODE_480P = 0;
    localparam int MODE_720P = 1;

    localparam video_mode_t M_480P = '{
        h_active: 12'd640,  h_fp: 12'd16,  h_sw: 12'd96, h_bp: 12'd48,
        v_active: 12'd480,  v_fp: 12'd10,  v_sw: 12'd2,  v_bp: 12'd33,
        hs_pol:   1'b0,     vs_pol: 1'b0
    };

    localparam video_mode_t M_720P = '{
        h_active: 12'd1280, h_fp: 12'd110, h_sw: 12'd40, h_bp: 12'd220,
        v_active: 12'd720,  v_fp: 12'd5,   v_sw: 12'd5,  v_bp: 12'd20,
        hs_pol:   1'b1,     vs_pol: 1'b1
    };

    // Packed so it can be passed as a module parameter; index 1 is the MSB slot.
    localparam video_mode_t [1:0] MODE_TABLE = {M_720P, M_480P};

endpackage

// File: rtl/video_axis_decode.sv
// Single-axis decoder: classifies a count against one axis of a mode.
// Ports: cnt, len_active/fp/sw/bp in; at_last, in_active, in_sync out.
module video_axis_decode
    import video_timing_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic [TW-1:0]    len_active,
    input  logic [TW-1:0]    len_fp,
    input  logic [TW-1:0]    len_sw,
    input  logic [TW-1:0]    len_bp,
    output logic             at_last,
    output logic             in_active,
    output logic             in_sync
);

    localparam int W = (CNT_W > TW) ? CNT_W : TW;

    logic [W-1:0] c;
    logic [W-1:0] sync_lo;
    logic [W-1:0] sync_hi;
    logic [W-1:0] last;

    assign c       = W'(cnt);
    assign sync_lo = W'(len_active) + W'(len_fp);
    assign sync_hi = sync_lo + W'(len_sw);
    assign last    = sync_hi + W'(len_bp) - W'(1);

    assign at_last   = (c == last);
    assign in_active = (c < W'(len_active));
    assign in_sync   = (c >= sync_lo) && (c < sync_hi);

endmodule

// File: rtl/video_timing_gen.sv
// Multi-mode video timing generator; mode switches only at frame wrap.
// Ports: i_clk_pxl, i_reset, i_mode_sel in; o_sx/o_sy/sync/de/nf/fc/mode out.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int NUM_MODES = 2,
    parameter int CNT_W     = 12,
    parameter int FPS       = 60,
    localparam int MODE_W   = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
    localparam int FC_W     = (FPS > 1) ? $clog2(FPS) : 1,
    parameter int SEL_W     = MODE_W,
    parameter video_mode_t [NUM_MODES-1:0] MODES = MODE_TABLE[NUM_MODES-1:0]
) (
    input  logic              i_clk_pxl,
    input  logic              i_reset,
    input  logic [SEL_W-1:0]  i_mode_sel,
    output logic [CNT_W-1:0]  o_sx,
    output logic [CNT_W-1:0]  o_sy,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_de,
    output logic              o_nf,
    output logic [FC_W-1:0]   o_fc,
    output logic [MODE_W-1:0] o_mode,
    output logic              o_mode_changed
);

    localparam int W = (CNT_W > TW) ? CNT_W : TW;
    localparam logic [SEL_W:0] NM = (SEL_W+1)'(NUM_MODES);

    logic [MODE_W-1:0] pend;
    logic [MODE_W-1:0] pend_n;
    logic [MODE_W-1:0] mode_n;
    logic [MODE_W-1:0] rst_mode;
    logic              sel_ok;

    // Registered "current position is the last on this axis" flags,
    // decoded one cycle early so the counters need no extra compare.
    logic              h_last_q;
    logic              v_last_q;
    logic              wrap;
    logic              swap;

    logic [CNT_W-1:0]  sx_n;
    logic [CNT_W-1:0]  sy_n;
    logic [FC_W-1:0]   fc_n;
    video_mode_t       nxt;

    logic h_last_n, h_act_n, h_sync_n;
    logic v_last_n, v_act_n, v_sync_n;
    logic nf_n;

    assign sel_ok   = ({1'b0, i_mode_sel} < NM);
    assign rst_mode = sel_ok ? i_mode_sel[MODE_W-1:0] : '0;
    assign pend_n   = sel_ok ? i_mode_sel[MODE_W-1:0] : pend;

    assign wrap   = h_last_q & v_last_q;
    assign swap   = wrap && (pend != o_mode);
    assign mode_n = swap ? pend : o_mode;

    assign sx_n = h_last_q ? '0 : o_sx + 1'b1;
    assign sy_n = h_last_q ? (v_last_q ? '0 : o_sy + 1'b1) : o_sy;

    always_comb begin
        fc_n = o_fc;
        if (swap)
            fc_n = '0;
        else if (wrap)
            fc_n = (o_fc == FC_W'(FPS-1)) ? '0 : o_fc + 1'b1;
    end

    // Decode the upcoming position in the mode it will be shown in,
    // so a freshly switched mode is correct from its very first pixel.
    assign nxt = MODES[mode_n];

    video_axis_decode #(.CNT_W(CNT_W)) u_h_dec (
        .cnt        (sx_n),
        .len_active (nxt.h_active),
        .len_fp     (nxt.h_fp),
        .len_sw     (nxt.h_sw),
        .len_bp     (nxt.h_bp),
        .at_last    (h_last_n),
        .in_active  (h_act_n),
        .in_sync    (h_sync_n)
    );

    video_axis_decode #(.CNT_W(CNT_W)) u_v_dec (
        .cnt        (sy_n),
        .len_active (nxt.v_active),
        .len_fp     (nxt.v_fp),
        .len_sw     (nxt.v_sw),
        .len_bp     (nxt.v_bp),
        .at_last    (v_last_n),
        .in_active  (v_act_n),
        .in_sync    (v_sync_n)
    );

    assign nf_n = (W'(sx_n) == W'(nxt.h_active)) &&
                  (W'(sy_n) + W'(1) == W'(nxt.v_active));

    always_ff @(posedge i_clk_pxl) begin
        if (i_reset) begin
            o_sx           <= '0;
            o_sy           <= '0;
            o_fc           <= '0;
            o_mode         <= rst_mode;
            pend           <= rst_mode;
            h_last_q       <= 1'b0;
            v_last_q       <= 1'b0;
            o_de           <= 1'b1;
            o_hsync        <= ~MODES[rst_mode].hs_pol;
            o_vsync        <= ~MODES[rst_mode].vs_pol;
            o_nf           <= 1'b0;
            o_mode_changed <= 1'b0;
        end else begin
            o_sx           <= sx_n;
            o_sy           <= sy_n;
            o_fc           <= fc_n;
            o_mode         <= mode_n;
            pend           <= pend_n;
            h_last_q       <= h_last_n;
            v_last_q       <= v_last_n;
            o_de           <= h_act_n & v_act_n;
            o_hsync        <= ~(h_sync_n ^ nxt.hs_pol);
            o_vsync        <= ~(v_sync_n ^ nxt.vs_pol);
            o_nf           <= nf_n;
            o_mode_changed <= swap;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench: real-table line checks on one DUT, model-checked small modes on another.
// Ports: none.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam video_mode_t T0 = '{
        h_active: 12'd8,  h_fp: 12'd2, h_sw: 12'd3, h_bp: 12'd2,
        v_active: 12'd5,  v_fp: 12'd1, v_sw: 12'd2, v_bp: 12'd1,
        hs_pol: 1'b0, vs_pol: 1'b0
    };
    localparam video_mode_t T1 = '{
        h_active: 12'd12, h_fp: 12'd3, h_sw: 12'd2, h_bp: 12'd3,
        v_active: 12'd6,  v_fp: 12'd2, v_sw: 12'd1, v_bp: 12'd2,
        hs_pol: 1'b1, vs_pol: 1'b1
    };
    localparam video_mode_t [1:0] TB_MODES = {T1, T0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // DUT1: small modes, widened select
    logic        rst1 = 1'b1;
    logic [1:0]  sel1 = 2'd1;
    logic [11:0] sx1, sy1;
    logic        hs1, vs1, de1, nf1, chg1;
    logic [5:0]  fc1;
    logic [0:0]  mode1;

    video_timing_gen #(.NUM_MODES(2), .CNT_W(12), .FPS(60),
                       .SEL_W(2), .MODES(TB_MODES)) u_dut1 (
        .i_clk_pxl(clk), .i_reset(rst1), .i_mode_sel(sel1),
        .o_sx(sx1), .o_sy(sy1), .o_hsync(hs1), .o_vsync(vs1),
        .o_de(de1), .o_nf(nf1), .o_fc(fc1), .o_mode(mode1),
        .o_mode_changed(chg1)
    );

    // DUT2: default package table
    logic        rst2 = 1'b1;
    logic [0:0]  sel2 = 1'b1;
    logic [11:0] sx2, sy2;
    logic        hs2, vs2, de2, nf2, chg2;
    logic [5:0]  fc2;
    logic [0:0]  mode2;

    video_timing_gen u_dut2 (
        .i_clk_pxl(clk), .i_reset(rst2), .i_mode_sel(sel2),
        .o_sx(sx2), .o_sy(sy2), .o_hsync(hs2), .o_vsync(vs2),
        .o_de(de2), .o_nf(nf2), .o_fc(fc2), .o_mode(mode2),
        .o_mode_changed(chg2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: linear pixel index within the frame.
    int m_p = 0, m_mode = 1, m_pend = 1, m_fc = 0, m_chg = 0;
    int n_nf = 0, n_chg = 0;

    function automatic video_mode_t cfg(input int m);
        return (m == 1) ? T1 : T0;
    endfunction
    function automatic int ht(input int m);
        video_mode_t c = cfg(m);
        return int'(c.h_active) + int'(c.h_fp) + int'(c.h_sw) + int'(c.h_bp);
    endfunction
    function automatic int vt(input int m);
        video_mode_t c = cfg(m);
        return int'(c.v_active) + int'(c.v_fp) + int'(c.v_sw) + int'(c.v_bp);
    endfunction

    task automatic step1(input logic r, input logic [1:0] s);
        video_mode_t c;
        int x, y, hlo, vlo, ehs, evs;
        rst1 = r;
        sel1 = s;
        @(posedge clk);
        if (r) begin
            m_mode = (s < 2) ? int'(s) : 0;
            m_pend = m_mode;
            m_p = 0; m_fc = 0; m_chg = 0;
        end else begin
            m_chg = 0;
            m_p++;
            if (m_p == ht(m_mode) * vt(m_mode)) begin
                m_p = 0;
                if (m_pend != m_mode) begin
                    m_mode = m_pend; m_fc = 0; m_chg = 1;
                end else begin
                    m_fc = (m_fc + 1) % 60;
                end
            end
            if (s < 2) m_pend = int'(s);
        end
        #1;
        c = cfg(m_mode);
        x = m_p % ht(m_mode);
        y = m_p / ht(m_mode);
        hlo = int'(c.h_active) + int'(c.h_fp);
        vlo = int'(c.v_active) + int'(c.v_fp);
        ehs = (x >= hlo && x < hlo + int'(c.h_sw)) ? int'(c.hs_pol) : int'(!c.hs_pol);
        evs = (y >= vlo && y < vlo + int'(c.v_sw)) ? int'(c.vs_pol) : int'(!c.vs_pol);
        chk("m_sx", sx1, x);
        chk("m_sy", sy1, y);
        chk("m_mode", mode1, m_mode);
        chk("m_fc", fc1, m_fc);
        chk("m_chg", chg1, m_chg);
        chk("m_hs", hs1, ehs);
        chk("m_vs", vs1, evs);
        chk("m_de", de1, int'(x < int'(c.h_active) && y < int'(c.v_active)));
        chk("m_nf", nf1, int'(x == int'(c.h_active) && y == int'(c.v_active) - 1));
        n_nf += int'(nf1);
        n_chg += int'(chg1);
    endtask

    typedef struct {
        logic sel;
        int   steps;
        int   ex_sx;
        int   ex_sy;
        logic ex_hs;
        logic ex_de;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int n, bad, c0;
        logic [1:0] rs;

        tbl[0]  = '{1'b1, 0,    0,    0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1,    1,    0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1279, 1279, 0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1280, 1280, 0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1389, 1389, 0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1390, 1390, 0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1429, 1429, 0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1430, 1430, 0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1649, 1649, 0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1650, 0,    1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 0,    0,    0, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 639,  639,  0, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 655,  655,  0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 656,  656,  0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 751,  751,  0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 752,  752,  0, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 800,  0,    1, 1'b1, 1'b1};

        for (int i = 0; i < 17; i++) begin
            rst2 = 1'b1;
            sel2 = tbl[i].sel;
            @(posedge clk);
            #1;
            rst2 = 1'b0;
            repeat (tbl[i].steps) @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_sx", i), sx2, tbl[i].ex_sx);
            chk($sformatf("tbl%0d_sy", i), sy2, tbl[i].ex_sy);
            chk($sformatf("tbl%0d_hs", i), hs2, tbl[i].ex_hs);
            chk($sformatf("tbl%0d_de", i), de2, tbl[i].ex_de);
            chk($sformatf("tbl%0d_vs", i), vs2, tbl[i].sel ? 0 : 1);
            chk($sformatf("tbl%0d_mode", i), mode2, tbl[i].sel);
            chk($sformatf("tbl%0d_nf", i), nf2, 0);
        end
        rst2 = 1'b1;

        step1(1'b1, 2'd1);
        step1(1'b1, 2'd1);
        chk("rst_sx", sx1, 0);
        chk("rst_de", de1, 1);
        n_nf = 0;
        n_chg = 0;
        for (int f = 1; f <= 60; f++) begin
            repeat (220) step1(1'b0, 2'd1);
            if (f == 1) chk("one_nf_per_frame", n_nf, 1);
            chk("fc_seq", fc1, f % 60);
            chk("frame_start_sx", sx1, 0);
            chk("frame_start_sy", sy1, 0);
        end
        chk("nf_total_60", n_nf, 60);
        chk("no_chg_60", n_chg, 0);

        n = 0;
        while (sy1 != 12'd5 && n < 500) begin step1(1'b0, 2'd1); n++; end
        chk("reach_sy5", int'(n < 500), 1);
        bad = 0;
        n = 0;
        do begin
            step1(1'b0, 2'd0);
            n++;
            if (!(sx1 == 0 && sy1 == 0) && mode1 != 1'b1) bad++;
        end while (!(sx1 == 0 && sy1 == 0) && n < 500);
        chk("no_midframe_switch", bad, 0);
        chk("sw_mode", mode1, 0);
        chk("sw_chg", chg1, 1);
        chk("sw_fc", fc1, 0);
        repeat (15) step1(1'b0, 2'd0);
        chk("m0_line_sx", sx1, 0);
        chk("m0_line_sy", sy1, 1);
        chk("m0_chg_gone", chg1, 0);

        c0 = n_chg;
        n = 0;
        while (sy1 != 12'd3 && n < 500) begin step1(1'b0, 2'd0); n++; end
        repeat (10) step1(1'b0, 2'd1);
        n = 0;
        do begin step1(1'b0, 2'd0); n++; end
        while (!(sx1 == 0 && sy1 == 0) && n < 500);
        chk("revert_wrap", int'(n < 500), 1);
        chk("revert_mode", mode1, 0);
        chk("revert_nochg", n_chg - c0, 0);

        repeat (270) step1(1'b0, 2'd3);
        chk("invalid_mode", mode1, 0);
        chk("invalid_nochg", n_chg - c0, 0);

        rs = 2'd1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(199) == 0) rs = 2'($urandom_range(3));
            step1(1'($urandom_range(999) == 0), rs);
        end

        n = 0;
        while (sy1 != 12'd4 && n < 500) begin step1(1'b0, rs); n++; end
        chk("reach_sy4", int'(n < 500), 1);
        step1(1'b1, 2'd1);
        chk("mid_rst_sx", sx1, 0);
        chk("mid_rst_sy", sy1, 0);
        chk("mid_rst_fc", fc1, 0);
        chk("mid_rst_de", de1, 1);
        chk("mid_rst_nf", nf1, 0);
        chk("mid_rst_chg", chg1, 0);
        step1(1'b0, 2'd1);
        chk("mid_rst_sx1", sx1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
